// File: rtl/morse_key_sequencer_pkg.sv
// Shared definitions for the Morse key sequencer: FSM state encodings,
// default timing constants and the registered output event bundle.
package morse_key_sequencer_pkg;

    localparam int unsigned DEF_CNT_W      = 4;
    localparam int unsigned DEF_DASH_MIN   = 2;
    localparam int unsigned DEF_LETTER_GAP = 3;
    localparam int unsigned DEF_WORD_GAP   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_e;

    // One registered event word toward the symbol-to-character translator.
    typedef struct packed {
        logic sym_valid;
        logic sym_dash;
        logic letter_end;
        logic word_end;
        logic busy;
    } evt_t;

endpackage

// File: rtl/morse_key_sequencer_dur_counter.sv
// Saturating duration counter in time units: synchronous clear has priority
// over the tick enable, and the count holds at all-ones instead of wrapping.
module morse_key_sequencer_dur_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/morse_key_sequencer.sv
// Morse key line decoder: times marks/spaces in ticks and emits dot/dash,
// letter-end and word-end pulses. Define KEY_DEBOUNCE_EN for a 2-sample key filter.
module morse_key_sequencer
    import morse_key_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned DASH_MIN   = DEF_DASH_MIN,
    parameter int unsigned LETTER_GAP = DEF_LETTER_GAP,
    parameter int unsigned WORD_GAP   = DEF_WORD_GAP
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic key,
    output logic sym_valid,
    output logic sym_dash,
    output logic letter_end,
    output logic word_end,
    output logic busy
);

    logic             key_q;
    logic             key_d;
    logic             key_prev_q;
    logic             key_prev_d;
    logic             key_rise;
    logic             key_fall;
    state_e           state_q;
    state_e           state_d;
    logic             from_idle_q;
    logic             from_idle_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             at_letter;
    logic             at_word;
    evt_t             evt_q;
    evt_t             evt_d;

`ifdef KEY_DEBOUNCE_EN
    logic raw_q;
    logic raw_d;

    // key_q follows the raw line only after two agreeing samples that differ from it.
    always_comb begin
        raw_d      = key;
        key_prev_d = key_q;
        key_d      = key_q;
        if ((key == raw_q) && (raw_q != key_q)) begin
            key_d = raw_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_q <= 1'b0;
        end else begin
            raw_q <= raw_d;
        end
    end
`else
    always_comb begin
        key_d      = key;
        key_prev_d = key_q;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q      <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_q      <= key_d;
            key_prev_q <= key_prev_d;
        end
    end

    assign key_rise  = key_q & ~key_prev_q;
    assign key_fall  = ~key_q & key_prev_q;
    assign at_letter = (32'(cnt) == (LETTER_GAP - 32'd1));
    assign at_word   = (32'(cnt) == (WORD_GAP - 32'd1));

    morse_key_sequencer_dur_counter #(
        .CNT_W (CNT_W)
    ) u_dur_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            from_idle_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            from_idle_q <= from_idle_d;
        end
    end

    // Next state and counter control; a key edge always beats a tick in the same cycle.
    always_comb begin
        state_d     = state_q;
        from_idle_d = from_idle_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (key_rise) begin
                    state_d     = ST_MARK;
                    from_idle_d = 1'b1;
                end
            end
            ST_MARK: begin
                if (key_fall) begin
                    cnt_clr = 1'b1;
                    // A zero-length mark is a glitch and returns to where it came from.
                    if ((cnt == '0) && from_idle_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SPACE;
                    end
                end else if (tick) begin
                    cnt_inc = 1'b1;
                end
            end
            ST_SPACE: begin
                if (key_rise) begin
                    state_d     = ST_MARK;
                    from_idle_d = 1'b0;
                    cnt_clr     = 1'b1;
                end else if (tick) begin
                    if (at_word) begin
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Output events, classified with the count as it stood before this cycle.
    always_comb begin
        evt_d      = '0;
        evt_d.busy = (state_d != ST_IDLE);
        if ((state_q == ST_MARK) && key_fall && (cnt != '0)) begin
            evt_d.sym_valid = 1'b1;
            evt_d.sym_dash  = (32'(cnt) >= DASH_MIN);
        end
        if ((state_q == ST_SPACE) && !key_rise && tick) begin
            evt_d.letter_end = at_letter;
            evt_d.word_end   = at_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign sym_valid  = evt_q.sym_valid;
    assign sym_dash   = evt_q.sym_dash;
    assign letter_end = evt_q.letter_end;
    assign word_end   = evt_q.word_end;
    assign busy       = evt_q.busy;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer: a table of key/tick segments with
// expected outputs, plus hand sequences for edge/tick collisions and reset.
module tb_morse_key_sequencer;

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DB = 1;
`else
    localparam int unsigned DB = 0;
`endif

    // Output word order: {sym_valid, sym_dash, letter_end, word_end, busy}
    localparam logic [4:0] E_IDLE = 5'b00000;
    localparam logic [4:0] E_BUSY = 5'b00001;
    localparam logic [4:0] E_DOT  = 5'b10001;
    localparam logic [4:0] E_DASH = 5'b11001;
    localparam logic [4:0] E_LET  = 5'b00101;
    localparam logic [4:0] E_WORD = 5'b00010;

    typedef struct {
        int unsigned n;
        logic        key;
        logic        tk;
        logic [4:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic key;
    logic sym_valid;
    logic sym_dash;
    logic letter_end;
    logic word_end;
    logic busy;
    logic [4:0] outs;

    int   checks = 0;
    int   errors = 0;
    vec_t rows[$];

    always #5 clk = ~clk;

    assign outs = {sym_valid, sym_dash, letter_end, word_end, busy};

    morse_key_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .key        (key),
        .sym_valid  (sym_valid),
        .sym_dash   (sym_dash),
        .letter_end (letter_end),
        .word_end   (word_end),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one clock cycle of inputs; returns at the next negedge.
    task automatic cyc(input logic k, input logic t);
        key  = k;
        tick = t;
        @(negedge clk);
    endtask

    task automatic add(input int unsigned n, input logic k, input logic t, input logic [4:0] e);
        rows.push_back('{n, k, t, e});
    endtask

    // Seven ticked space segments from a fresh space back to idle.
    task automatic add_space_to_idle();
        add(10, 1'b0, 1'b1, E_BUSY);
        add(10, 1'b0, 1'b1, E_BUSY);
        add(10, 1'b0, 1'b1, E_LET);
        add(10, 1'b0, 1'b1, E_BUSY);
        add(10, 1'b0, 1'b1, E_BUSY);
        add(10, 1'b0, 1'b1, E_BUSY);
        add(10, 1'b0, 1'b1, E_WORD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic spur;

        // One-tick mark is a dot.
        add(2 + DB, 1'b1, 1'b0, E_BUSY);
        add(10, 1'b1, 1'b1, E_BUSY);
        add(2 + DB, 1'b0, 1'b0, E_DOT);
        // Three-tick mark is a dash, then letter and word gaps.
        add(2 + DB, 1'b1, 1'b0, E_BUSY);
        for (int i = 0; i < 3; i++) add(10, 1'b1, 1'b1, E_BUSY);
        add(2 + DB, 1'b0, 1'b0, E_DASH);
        add_space_to_idle();
        // Exactly DASH_MIN ticks is a dash.
        add(2 + DB, 1'b1, 1'b0, E_BUSY);
        for (int i = 0; i < 2; i++) add(10, 1'b1, 1'b1, E_BUSY);
        add(2 + DB, 1'b0, 1'b0, E_DASH);
        add_space_to_idle();
        // Mark with no tick is a glitch back to idle.
        add(4, 1'b1, 1'b0, E_BUSY);
        add(2 + DB, 1'b0, 1'b0, E_IDLE);
        // Twenty-tick mark saturates and stays a dash.
        add(2 + DB, 1'b1, 1'b0, E_BUSY);
        for (int i = 0; i < 20; i++) add(10, 1'b1, 1'b1, E_BUSY);
        add(2 + DB, 1'b0, 1'b0, E_DASH);
        add_space_to_idle();

        reset = 1'b1;
        key   = 1'b0;
        tick  = 1'b0;
        #2 reset = 1'b0;
        #1 chk("reset_state", outs, E_IDLE);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < rows.size(); i++) begin
            spur = 1'b0;
            for (int c = 0; c < int'(rows[i].n); c++) begin
                cyc(rows[i].key, rows[i].tk && (c == int'(rows[i].n) - 1));
                if ((c < int'(rows[i].n) - 1) && (sym_valid || letter_end || word_end)) spur = 1'b1;
            end
            chk($sformatf("row%0d", i), outs, rows[i].exp);
            chk($sformatf("row%0d_quiet", i), {4'b0, spur}, 5'b0);
        end

        // Counter must not wrap after 16 ticks.
        repeat (2 + DB) cyc(1'b1, 1'b0);
        repeat (16) cyc(1'b1, 1'b1);
        repeat (2 + DB) cyc(1'b0, 1'b0);
        chk("sat_16", outs, E_DASH);
        repeat (7) cyc(1'b0, 1'b1);
        chk("sat_16_word", outs, E_WORD);

        // Tick coinciding with the key fall is dropped; one counted tick stays a dot.
        repeat (2 + DB) cyc(1'b1, 1'b0);
        repeat (9) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (1 + DB) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("tick_on_fall", outs, E_DOT);
        // Tick coinciding with a rise at space count 2 must not raise letter_end.
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        repeat (1 + DB) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("tick_on_rise", outs, E_BUSY);
        // Glitch entered from space returns to space with the count restarted.
        repeat (1 + DB) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("glitch_to_space", outs, E_BUSY);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("restart_t2", outs, E_BUSY);
        cyc(1'b0, 1'b1);
        chk("restart_letter", outs, E_LET);
        repeat (3) cyc(1'b0, 1'b1);
        chk("restart_t6", outs, E_BUSY);
        cyc(1'b0, 1'b1);
        chk("restart_word", outs, E_WORD);

        // Asynchronous reset mid-mark drops the pending symbol.
        repeat (2 + DB) cyc(1'b1, 1'b0);
        repeat (9) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("pre_reset_busy", outs, E_BUSY);
        #3 reset = 1'b0;
        #1 chk("async_reset", outs, E_IDLE);
        key = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        spur = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 1'b1);
            if (outs != E_IDLE) spur = 1'b1;
        end
        chk("no_sym_after_reset", {4'b0, spur}, 5'b0);

        // Key still held across reset release gives a fresh mark.
        repeat (2 + DB) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        #3 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2 + DB) cyc(1'b1, 1'b0);
        chk("held_key_mark", outs, E_BUSY);
        repeat (9) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (2 + DB) cyc(1'b0, 1'b0);
        chk("held_key_dot", outs, E_DOT);
        repeat (7) cyc(1'b0, 1'b1);
        chk("held_key_word", outs, E_WORD);

`ifdef KEY_DEBOUNCE_EN
        // One-cycle key pulse is filtered out.
        cyc(1'b1, 1'b0);
        spur = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 1'b0);
            if (outs != E_IDLE) spur = 1'b1;
        end
        chk("pulse_rejected", {4'b0, spur}, 5'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
